// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the f1/f2 truth-table sweep controller.
package tt_sweep_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} sweep_state_t;

  localparam logic [7:0]  TT_DEF_EXP_F1 = 8'hF2;
  localparam logic [7:0]  TT_DEF_EXP_F2 = 8'h3A;
  localparam int unsigned TT_NVEC       = 8;

endpackage

// File: rtl/tt_sweep_ctrl.sv
// Walks {x,y,z} through all 8 vectors, captures f1/f2 into truth tables and
// compares them against the expected tables, reporting the first mismatch.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  EXP_F1        = TT_DEF_EXP_F1,
  parameter logic [7:0]  EXP_F2        = TT_DEF_EXP_F2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       x,
  output logic       y,
  output logic       z,
  input  logic       f1_in,
  input  logic       f2_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_f1,
  output logic [7:0] tt_f2,
  output logic       pass,
  output logic       err_valid,
  output logic [2:0] err_idx
);

  localparam int unsigned   CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST = 3'(TT_NVEC - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("tt_sweep_ctrl: SETTLE_CYCLES must be >= 1");
  end

  sweep_state_t  state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          miss;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start && !abort) state_d = SETTLE;
      SETTLE:  if (abort) state_d = IDLE;
               else if (cnt == CNT_LAST) state_d = CAPTURE;
      CAPTURE: if (abort) state_d = IDLE;
               else if (idx == IDX_LAST) state_d = DONE;
               else state_d = SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SETTLE) || (state == CAPTURE);
    done = (state == DONE);
    miss = (f1_in != EXP_F1[idx]) || (f2_in != EXP_F2[idx]);
  end

  // idx doubles as the registered {x,y,z} drive, so it is 0 whenever IDLE.
  assign {x, y, z} = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      tt_f1     <= '0;
      tt_f2     <= '0;
      pass      <= 1'b0;
      err_valid <= 1'b0;
      err_idx   <= '0;
    end else begin
      state <= state_d;
      cnt   <= (state == SETTLE && state_d == SETTLE) ? cnt + 1'b1 : '0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            idx       <= '0;
            tt_f1     <= '0;
            tt_f2     <= '0;
            pass      <= 1'b0;
            err_valid <= 1'b0;
            err_idx   <= '0;
          end
        end
        CAPTURE: begin
          if (!abort) begin
            tt_f1[idx] <= f1_in;
            tt_f2[idx] <= f2_in;
            if (miss && !err_valid) begin
              err_valid <= 1'b1;
              err_idx   <= idx;
            end
            // Verdict formed on the last capture so it is already valid while done is high.
            if (idx == IDX_LAST) begin
              pass <= ({f1_in, tt_f1[6:0]} == EXP_F1) && ({f2_in, tt_f2[6:0]} == EXP_F2);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (state_d == IDLE) idx <= '0;
      if (state == DONE && abort) pass <= 1'b0;
    end
  end

endmodule
